prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader.sv | 232 +++++++++++++++++++++++
 tb/tb_prog_loader.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// -----------------------------------------------------------------------------
// prog_loader
//   Receives a program image over a UART line (8N1, LSB first) into a 16 x 8
//   instruction memory and controls the run enable of the attached CPU.
//
//   Image format: sync byte 0xA5, 16 data bytes (written to mem[0..15]),
//   then one checksum byte (sum of the 16 data bytes mod 256).
//
// Ports
//   clk          sole clock, rising edge
//   reset        asynchronous active-low reset
//   rxd          UART serial input, idle high
//   addr         CPU fetch address
//   dout         mem[addr], combinational
//   cpu_reset_n  low holds the CPU in reset (registered)
//   busy         high while an image is being received (registered)
//   err          sticky failed-load flag (registered)
// -----------------------------------------------------------------------------
module prog_loader #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    input  logic [3:0] addr,
    output logic [7:0] dout,
    output logic       cpu_reset_n,
    output logic       busy,
    output logic       err
);

    localparam logic [15:0] FULL_M1 = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [7:0]  SYNC    = 8'hA5;

    // -------------------------------------------------------------------------
    // Input synchronizer. All three flops reset low, so after reset release a
    // falling edge can only be seen once the line has been observed high.
    // -------------------------------------------------------------------------
    logic rxd_s1_q, rxd_s2_q, rxd_prev_q;
    logic start_edge;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rxd_s1_q   <= 1'b0;
            rxd_s2_q   <= 1'b0;
            rxd_prev_q <= 1'b0;
        end else begin
            rxd_s1_q   <= rxd;
            rxd_s2_q   <= rxd_s1_q;
            rxd_prev_q <= rxd_s2_q;
        end
    end

    assign start_edge = rxd_prev_q & ~rxd_s2_q;

    // -------------------------------------------------------------------------
    // UART receiver
    // -------------------------------------------------------------------------
    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    rx_state_e   rx_state_q;
    logic [15:0] rx_cnt_q;
    logic [2:0]  rx_bit_q;
    logic [7:0]  rx_shift_q;
    logic        rx_tick;
    logic        byte_valid;
    logic        frame_err;

    // Start bit is checked at its midpoint; every later sample is one full
    // bit period after the previous one, landing on bit centres.
    assign rx_tick = (rx_state_q == RX_START) ? (rx_cnt_q == HALF_M1)
                                              : (rx_cnt_q == FULL_M1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
        end else begin
            case (rx_state_q)
                RX_IDLE: begin
                    rx_cnt_q <= '0;
                    if (start_edge) rx_state_q <= RX_START;
                end
                RX_START: begin
                    if (rx_tick) begin
                        rx_cnt_q   <= '0;
                        rx_bit_q   <= '0;
                        // Line back high at mid start bit: treat as a glitch.
                        rx_state_q <= rxd_s2_q ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 16'd1;
                    end
                end
                RX_DATA: begin
                    if (rx_tick) begin
                        rx_cnt_q   <= '0;
                        rx_shift_q <= {rxd_s2_q, rx_shift_q[7:1]};
                        rx_bit_q   <= rx_bit_q + 3'd1;
                        if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 16'd1;
                    end
                end
                RX_STOP: begin
                    if (rx_tick) begin
                        rx_cnt_q   <= '0;
                        rx_state_q <= RX_IDLE;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 16'd1;
                    end
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

    // One-cycle strobes, asserted in the cycle whose closing edge samples the
    // stop bit, so the load FSM acts on the same edge.
    assign byte_valid = (rx_state_q == RX_STOP) && rx_tick &&  rxd_s2_q;
    assign frame_err  = (rx_state_q == RX_STOP) && rx_tick && !rxd_s2_q;

    // -------------------------------------------------------------------------
    // Load FSM with registered outputs
    // -------------------------------------------------------------------------
    typedef enum logic [2:0] {
        HOLD,
        RUN,
        LOAD,
        CHECK,
        FAIL
    } ld_state_e;

    ld_state_e  ld_state_q;
    logic [3:0] idx_q;
    logic [7:0] sum_q;
    logic [7:0] sum_d;
    logic       cpu_reset_n_q;
    logic       busy_q;
    logic       err_q;

    assign sum_d = sum_q + rx_shift_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ld_state_q    <= HOLD;
            idx_q         <= '0;
            sum_q         <= '0;
            cpu_reset_n_q <= 1'b0;
            busy_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            case (ld_state_q)
                // Idle states differ only in outputs; all wait for the sync
                // byte and ignore everything else, including frame errors.
                HOLD, RUN, FAIL: begin
                    if (byte_valid && rx_shift_q == SYNC) begin
                        ld_state_q    <= LOAD;
                        idx_q         <= '0;
                        sum_q         <= '0;
                        cpu_reset_n_q <= 1'b0;
                        busy_q        <= 1'b1;
                    end
                end
                LOAD: begin
                    if (frame_err) begin
                        ld_state_q <= FAIL;
                        busy_q     <= 1'b0;
                        err_q      <= 1'b1;
                    end else if (byte_valid) begin
                        sum_q <= sum_d;
                        idx_q <= idx_q + 4'd1;
                        if (idx_q == 4'd15) ld_state_q <= CHECK;
                    end
                end
                CHECK: begin
                    if (frame_err) begin
                        ld_state_q <= FAIL;
                        busy_q     <= 1'b0;
                        err_q      <= 1'b1;
                    end else if (byte_valid) begin
                        busy_q <= 1'b0;
                        if (rx_shift_q == sum_q) begin
                            ld_state_q    <= RUN;
                            cpu_reset_n_q <= 1'b1;
                            err_q         <= 1'b0;
                        end else begin
                            ld_state_q <= FAIL;
                            err_q      <= 1'b1;
                        end
                    end
                end
                default: begin
                    ld_state_q    <= HOLD;
                    cpu_reset_n_q <= 1'b0;
                    busy_q        <= 1'b0;
                end
            endcase
        end
    end

    assign cpu_reset_n = cpu_reset_n_q;
    assign busy        = busy_q;
    assign err         = err_q;

    // -------------------------------------------------------------------------
    // Program memory: written on the edge that accepts a data byte, read
    // combinationally so the fetch path sees new data the next cycle.
    // -------------------------------------------------------------------------
    logic [7:0] mem_q [16];
    logic       wr_en;

    assign wr_en = (ld_state_q == LOAD) && byte_valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) mem_q[i] <= '0;
        end else if (wr_en) begin
            mem_q[idx_q] <= rx_shift_q;
        end
    end

    assign dout = mem_q[addr];

endmodule

// File: tb/tb_prog_loader.sv
// -----------------------------------------------------------------------------
// tb_prog_loader
//   Drives UART frames into prog_loader (CLKS_PER_BIT=8) and compares outputs
//   and memory against a byte-level model of the image protocol.
// -----------------------------------------------------------------------------
module tb_prog_loader;

    localparam int CPB = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       rxd;
    logic [3:0] addr;
    logic [7:0] dout;
    logic       cpu_reset_n;
    logic       busy;
    logic       err;

    always #5 clk = ~clk;

    prog_loader #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .reset      (reset),
        .rxd        (rxd),
        .addr       (addr),
        .dout       (dout),
        .cpu_reset_n(cpu_reset_n),
        .busy       (busy),
        .err        (err)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model (byte level) ----------------
    logic [7:0] m_mem [16];
    logic [7:0] img [$];
    bit         m_run;
    bit         m_err;
    bit         m_loading;

    task automatic model_reset();
        foreach (m_mem[i]) m_mem[i] = 8'h00;
        img.delete();
        m_run = 0; m_err = 0; m_loading = 0;
    endtask

    task automatic model_byte(input logic [7:0] b, input logic ok);
        int s;
        if (!m_loading) begin
            if (ok && b == 8'hA5) begin
                m_loading = 1; m_run = 0; img.delete();
            end
        end else if (!ok) begin
            m_loading = 0; m_err = 1; m_run = 0;
        end else if (img.size() < 16) begin
            m_mem[img.size()] = b;
            img.push_back(b);
        end else begin
            s = 0;
            foreach (img[i]) s += int'(img[i]);
            if (b == 8'(s % 256)) begin m_err = 0; m_run = 1; end
            else begin m_err = 1; m_run = 0; end
            m_loading = 0;
        end
    endtask

    // ---------------- stimulus helpers ----------------
    logic snap_cr_early, snap_cr, snap_busy;

    // Starts and ends on a falling clock edge.
    task automatic send_byte(input logic [7:0] b, input logic stop);
        logic [9:0] frame;
        frame = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rxd = frame[i];
            for (int c = 0; c < CPB; c++) begin
                @(negedge clk);
                if (i == 9 && c == 2) snap_cr_early = cpu_reset_n;
                if (i == 9 && c == 6) begin
                    snap_cr   = cpu_reset_n;
                    snap_busy = busy;
                end
            end
        end
        rxd = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic chk_outs(input string tag);
        chk({tag, ".cpu_reset_n"}, 8'(cpu_reset_n), 8'(m_run));
        chk({tag, ".busy"},        8'(busy),        8'(m_loading));
        chk({tag, ".err"},         8'(err),         8'(m_err));
    endtask

    task automatic send_chk(input string tag, input logic [7:0] b, input logic stop);
        send_byte(b, stop);
        model_byte(b, stop);
        chk_outs(tag);
    endtask

    task automatic chk_mem(input string tag);
        for (int a = 0; a < 16; a++) begin
            addr = 4'(a);
            #1;
            chk({tag, ".dout"}, dout, m_mem[a]);
        end
        addr = 4'd0;
    endtask

    logic [7:0] buf_q [16];

    function automatic logic [7:0] buf_sum();
        int s;
        s = 0;
        foreach (buf_q[i]) s += int'(buf_q[i]);
        return 8'(s % 256);
    endfunction

    task automatic fill_random();
        foreach (buf_q[i]) buf_q[i] = 8'($urandom_range(0, 255));
    endtask

    task automatic send_image(input string tag, input logic [7:0] csum);
        send_chk({tag, ".sync"}, 8'hA5, 1'b1);
        foreach (buf_q[i]) send_chk({tag, ".data"}, buf_q[i], 1'b1);
        send_chk({tag, ".csum"}, csum, 1'b1);
        chk_mem(tag);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [7:0] b;
        model_reset();
        reset = 1'b0;
        rxd   = 1'b1;
        addr  = 4'd0;
        repeat (5) @(negedge clk);
        chk_outs("rst");
        chk_mem("rst");
        reset = 1'b1;
        repeat (5) @(negedge clk);

        // Known image 00..0F, checksum 0x78
        foreach (buf_q[i]) buf_q[i] = 8'(i);
        send_image("img0", 8'h78);
        addr = 4'd3;
        #1;
        chk("img0.addr3", dout, 8'h03);

        // Non-sync byte in RUN is ignored; sync drops the CPU promptly
        send_chk("run55", 8'h55, 1'b1);
        send_chk("runA5", 8'hA5, 1'b1);
        chk("runA5.cr_before", 8'(snap_cr_early), 8'h01);
        chk("runA5.cr_after",  8'(snap_cr),       8'h00);
        chk("runA5.busy",      8'(snap_busy),     8'h01);
        fill_random();
        foreach (buf_q[i]) send_chk("run.data", buf_q[i], 1'b1);
        send_chk("run.csum", buf_sum(), 1'b1);
        chk_mem("run");

        // Bad checksum, then recovery
        foreach (buf_q[i]) buf_q[i] = 8'hFF;
        send_image("badsum", 8'h00);
        chk("badsum.err", 8'(err), 8'h01);
        fill_random();
        send_image("recover", buf_sum());

        // Frame error on the 5th image byte
        fill_random();
        send_chk("ferr.sync", 8'hA5, 1'b1);
        for (int i = 0; i < 4; i++) send_chk("ferr.data", buf_q[i], 1'b1);
        send_chk("ferr.bad", buf_q[4], 1'b0);
        chk_mem("ferr");

        // Quarter-bit glitch on idle line in the middle of a load
        fill_random();
        send_chk("glitch.sync", 8'hA5, 1'b1);
        for (int i = 0; i < 3; i++) send_chk("glitch.data", buf_q[i], 1'b1);
        rxd = 1'b0;
        repeat (CPB / 4) @(negedge clk);
        rxd = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        chk_outs("glitch.idle");
        for (int i = 3; i < 16; i++) send_chk("glitch.data", buf_q[i], 1'b1);
        send_chk("glitch.csum", buf_sum(), 1'b1);
        chk_mem("glitch");

        // Randomized traffic
        for (int it = 0; it < 6; it++) begin
            for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
                b = 8'($urandom_range(0, 255));
                if (b == 8'hA5) b = 8'h5A;
                send_chk("rnd.junk", b, 1'($urandom_range(0, 1)));
            end
            fill_random();
            send_chk("rnd.sync", 8'hA5, 1'b1);
            for (int i = 0; i < 16; i++) begin
                if ($urandom_range(0, 40) == 0) begin
                    send_chk("rnd.ferr", buf_q[i], 1'b0);
                    break;
                end
                send_chk("rnd.data", buf_q[i], 1'b1);
            end
            if (m_loading) begin
                b = buf_sum();
                if ($urandom_range(0, 2) == 0) b = b ^ 8'(1 << $urandom_range(0, 7));
                send_chk("rnd.csum", b, 1'b1);
            end
            chk_mem("rnd");
        end

        // Reset during the 10th image byte
        fill_random();
        send_chk("rst2.sync", 8'hA5, 1'b1);
        for (int i = 0; i < 9; i++) send_chk("rst2.data", buf_q[i], 1'b1);
        rxd = 1'b0;
        repeat (CPB + 3) @(negedge clk);
        reset = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk_outs("rst2.held");
        chk_mem("rst2.held");
        reset = 1'b1;                       // release while line still low
        repeat (10) @(negedge clk);
        rxd = 1'b1;
        repeat (12) @(negedge clk);
        chk_outs("rst2.rel");
        chk_mem("rst2.rel");
        fill_random();
        send_image("rst2.img", buf_sum());

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
